// File: rtl/keypad_key_decoder.sv
// Turns scanner press events into 4-bit key codes with optional auto-repeat,
// buffered in a small valid/ready FIFO for the UI / PIN consumer.
module keypad_key_decoder #(
    parameter int          DEPTH        = 4,
    parameter logic [15:0] REPEAT_DELAY = 16'd0,
    parameter logic [15:0] REPEAT_RATE  = 16'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keypad_col_in,
    input  logic [3:0] row_in,
    input  logic       key_pressed,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_error,
    output logic       overflow,
    input  logic       clear
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_HELD         = 2'd1;
    localparam logic [1:0] S_REPEAT       = 2'd2;
    localparam logic [1:0] S_WAIT_RELEASE = 2'd3;

    function automatic logic is_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] one_hot_idx(input logic [3:0] v);
        logic [1:0] idx;
        case (v)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Rows 0..2 follow the phone layout; row 3 carries '*'=E, 0, '#'=F, D.
    function automatic logic [3:0] decode_key(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  code_q, code_d;
    logic        key_pressed_q;
    logic        key_error_q, overflow_q;
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic [3:0]  mem_q [DEPTH];

    logic        press_s, press_ok_s, push_s, err_s;
    logic [3:0]  new_code_s, push_code_s;
    logic        empty_s, full_s, pop_s, write_s, drop_s;

    assign press_s    = key_pressed && !key_pressed_q;
    assign press_ok_s = is_one_hot(row_in) && is_one_hot(keypad_col_in);
    assign new_code_s = decode_key(one_hot_idx(row_in), one_hot_idx(keypad_col_in));

    // Press / hold / repeat state machine; release always beats a repeat tick.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        push_s      = 1'b0;
        err_s       = 1'b0;
        push_code_s = code_q;
        case (state_q)
            S_IDLE: begin
                if (press_s && press_ok_s) begin
                    push_s      = 1'b1;
                    push_code_s = new_code_s;
                    code_d      = new_code_s;
                    cnt_d       = 16'd0;
                    state_d     = S_HELD;
                end else if (press_s) begin
                    err_s   = 1'b1;
                    state_d = S_WAIT_RELEASE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HELD: begin
                if (!key_pressed) begin
                    cnt_d   = 16'd0;
                    state_d = S_IDLE;
                end else if ((REPEAT_DELAY != 16'd0) && (cnt_q == REPEAT_DELAY - 16'd1)) begin
                    push_s  = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = S_REPEAT;
                end else if (REPEAT_DELAY != 16'd0) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_REPEAT: begin
                if (!key_pressed) begin
                    cnt_d   = 16'd0;
                    state_d = S_IDLE;
                end else if ((REPEAT_RATE != 16'd0) && (cnt_q == REPEAT_RATE - 16'd1)) begin
                    push_s = 1'b1;
                    cnt_d  = 16'd0;
                end else if (REPEAT_RATE != 16'd0) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            S_WAIT_RELEASE: begin
                if (!key_pressed) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WAIT_RELEASE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 16'd0;
            end
        endcase
        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = 16'd0;
            push_s  = 1'b0;
            err_s   = 1'b0;
        end else begin
            state_d = state_d;
        end
    end

    assign empty_s = (wr_ptr_q == rd_ptr_q);
    assign full_s  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_s   = !clear && !empty_s && key_ready;
    assign write_s = push_s && (!full_s || pop_s);
    assign drop_s  = push_s && full_s && !pop_s;

    // FSM, edge-detect and error-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= 16'd0;
            code_q        <= 4'd0;
            key_pressed_q <= 1'b0;
            key_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            code_q        <= code_d;
            key_pressed_q <= key_pressed;
            key_error_q   <= err_s;
        end
    end

    // FIFO storage, pointers and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 4'd0;
            end
        end else if (clear) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (write_s) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_code_s;
                wr_ptr_q                <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            if (drop_s) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign key_code  = mem_q[rd_ptr_q[AW-1:0]];
    assign key_valid = !empty_s;
    assign key_error = key_error_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_keypad_key_decoder.sv
// Scoreboard bench: expected codes are queued as presses are driven and
// compared as the consumer pops them; two instances cover no-repeat and repeat.
module tb_keypad_key_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] keypad_col_in;
    logic [3:0] row_in;
    logic       key_pressed;
    logic       key_ready;
    logic       clear;

    logic [3:0] d_code, r_code;
    logic       d_valid, r_valid, d_error, r_error, d_ovf, r_ovf;

    logic       sel_rep;
    logic [3:0] obs_code;
    logic       obs_valid, obs_error, obs_ovf;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_pops  = 0;
    int         pops0;
    logic [3:0] exp_q [$];

    always #5 clk = ~clk;

    keypad_key_decoder u_dut (
        .clk(clk), .rst(rst), .keypad_col_in(keypad_col_in), .row_in(row_in),
        .key_pressed(key_pressed), .key_code(d_code), .key_valid(d_valid),
        .key_ready(key_ready), .key_error(d_error), .overflow(d_ovf), .clear(clear)
    );

    keypad_key_decoder #(.DEPTH(4), .REPEAT_DELAY(16'd8), .REPEAT_RATE(16'd4)) u_rep (
        .clk(clk), .rst(rst), .keypad_col_in(keypad_col_in), .row_in(row_in),
        .key_pressed(key_pressed), .key_code(r_code), .key_valid(r_valid),
        .key_ready(key_ready), .key_error(r_error), .overflow(r_ovf), .clear(clear)
    );

    assign obs_code  = sel_rep ? r_code  : d_code;
    assign obs_valid = sel_rep ? r_valid : d_valid;
    assign obs_error = sel_rep ? r_error : d_error;
    assign obs_ovf   = sel_rep ? r_ovf   : d_ovf;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] code_of(input logic [3:0] row, input logic [3:0] col);
        logic [3:0] tab [16];
        int r;
        int c;
        tab = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
        r = 0;
        c = 0;
        for (int i = 0; i < 4; i++) begin
            if (row[i]) r = i;
            if (col[i]) c = i;
        end
        return tab[r * 4 + c];
    endfunction

    // Consumer side: every handshake pops one expected code.
    always @(negedge clk) begin
        if (!rst && !clear && key_ready && obs_valid) begin
            check_eq("pop_expected", (exp_q.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (exp_q.size() != 0) begin
                check_eq("pop_code", obs_code, exp_q.pop_front());
            end
            n_pops++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_key(input logic [3:0] row, input logic [3:0] col,
                             input int hold, input bit expect_push);
        row_in        = row;
        keypad_col_in = col;
        key_pressed   = 1'b1;
        if (expect_push) exp_q.push_back(code_of(row, col));
        step(hold);
        key_pressed = 1'b0;
        step(1);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0) break;
            step(1);
        end
        step(1);
        check_eq("drain_q_empty", exp_q.size(), 32'd0);
        check_eq("drain_valid", obs_valid, 1'b0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; row_in = 4'd0; keypad_col_in = 4'd0; key_pressed = 1'b0;
        key_ready = 1'b0; clear = 1'b0; sel_rep = 1'b0;
        step(3);
        check_eq("rst_code", d_code, 4'd0);
        check_eq("rst_valid", d_valid, 1'b0);
        check_eq("rst_error", d_error, 1'b0);
        check_eq("rst_ovf", d_ovf, 1'b0);
        rst = 1'b0;
        step(2);

        // Single press, code 8, exactly one pop.
        key_ready = 1'b1;
        pops0 = n_pops;
        row_in = 4'b0100; keypad_col_in = 4'b0010; key_pressed = 1'b1;
        exp_q.push_back(code_of(4'b0100, 4'b0010));
        step(1);
        @(negedge clk);
        check_eq("t1_valid", d_valid, 1'b1);
        check_eq("t1_code", d_code, 4'h8);
        step(9);
        key_pressed = 1'b0;
        step(3);
        check_eq("t1_pops", n_pops - pops0, 32'd1);
        check_eq("t1_valid_after", d_valid, 1'b0);
        check_eq("t1_error", d_error, 1'b0);

        // Invalid press, then re-press required for a valid code.
        row_in = 4'b0110; keypad_col_in = 4'b0001; key_pressed = 1'b1;
        step(1);
        @(negedge clk);
        check_eq("t2_err_pulse", d_error, 1'b1);
        check_eq("t2_no_push", d_valid, 1'b0);
        step(1);
        @(negedge clk);
        check_eq("t2_err_end", d_error, 1'b0);
        row_in = 4'b1000; keypad_col_in = 4'b0100;
        step(4);
        check_eq("t2_wait_release", d_valid, 1'b0);
        key_pressed = 1'b0;
        step(1);
        press_key(4'b1000, 4'b0100, 3, 1'b1);
        step(3);
        check_eq("t2_q_empty", exp_q.size(), 32'd0);

        // Overflow: five presses into a four-entry FIFO.
        key_ready = 1'b0;
        press_key(4'b0001, 4'b0001, 2, 1'b1);
        press_key(4'b0010, 4'b0010, 2, 1'b1);
        press_key(4'b0100, 4'b0100, 2, 1'b1);
        press_key(4'b1000, 4'b1000, 2, 1'b1);
        press_key(4'b0001, 4'b1000, 2, 1'b0);
        check_eq("t3_ovf", d_ovf, 1'b1);
        check_eq("t3_head", d_code, 4'h1);
        key_ready = 1'b1;
        drain(20);
        check_eq("t3_ovf_sticky", d_ovf, 1'b1);
        key_ready = 1'b0;
        pulse_clear();
        check_eq("t3_ovf_cleared", d_ovf, 1'b0);
        check_eq("t3_clear_valid", d_valid, 1'b0);

        // Full FIFO with a simultaneous pop and push.
        press_key(4'b0001, 4'b0010, 2, 1'b1);
        press_key(4'b0001, 4'b0100, 2, 1'b1);
        press_key(4'b0010, 4'b0001, 2, 1'b1);
        press_key(4'b0010, 4'b0100, 2, 1'b1);
        row_in = 4'b0100; keypad_col_in = 4'b0001; key_pressed = 1'b1; key_ready = 1'b1;
        exp_q.push_back(code_of(4'b0100, 4'b0001));
        step(1);
        key_ready = 1'b0;
        check_eq("t5_ovf", d_ovf, 1'b0);
        check_eq("t5_valid", d_valid, 1'b1);
        check_eq("t5_head", d_code, 4'h3);
        step(1);
        key_pressed = 1'b0;
        step(1);
        key_ready = 1'b1;
        drain(20);
        check_eq("t5_ovf_after", d_ovf, 1'b0);

        // Auto-repeat on the repeating instance: 7 pushes of '5'.
        key_ready = 1'b0;
        pulse_clear();
        sel_rep = 1'b1;
        check_eq("t4_ovf_clear", r_ovf, 1'b0);
        key_ready = 1'b1;
        pops0 = n_pops;
        row_in = 4'b0010; keypad_col_in = 4'b0010; key_pressed = 1'b1;
        for (int i = 0; i < 7; i++) exp_q.push_back(4'h5);
        step(30);
        key_pressed = 1'b0;
        step(12);
        check_eq("t4_pops", n_pops - pops0, 32'd7);
        check_eq("t4_q_empty", exp_q.size(), 32'd0);
        check_eq("t4_valid", r_valid, 1'b0);

        // Reset during REPEAT with two codes queued, key still held after.
        key_ready = 1'b0;
        row_in = 4'b0100; keypad_col_in = 4'b1000; key_pressed = 1'b1;
        step(10);
        check_eq("t6_pre_valid", r_valid, 1'b1);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", r_valid, 1'b0);
        check_eq("t6_rst_code", r_code, 4'd0);
        check_eq("t6_rst_ovf", r_ovf, 1'b0);
        check_eq("t6_rst_err", r_error, 1'b0);
        exp_q.delete();
        step(2);
        rst = 1'b0;
        exp_q.push_back(code_of(4'b0100, 4'b1000));
        step(1);
        @(negedge clk);
        check_eq("t6_new_valid", r_valid, 1'b1);
        check_eq("t6_new_code", r_code, 4'hC);
        step(2);
        key_pressed = 1'b0;
        key_ready = 1'b1;
        drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_key_decoder.md
Name: keypad_key_decoder

Overview:
- Sits directly downstream of the keypad scanner/poller.
- Consumes the scanner's held column drive, latched row, and key-pressed level.
- Converts each new press into a 4-bit key code, with optional auto-repeat while the key is held.
- Buffers codes in a small FIFO with a valid/ready interface to the consumer (UI/PIN logic).

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- REPEAT_DELAY, 16'd0: cycles key_pressed must stay high after the initial push before the first repeat; 0 disables auto-repeat.
- REPEAT_RATE, 16'd0: cycles between subsequent repeats; 0 means one repeat only after REPEAT_DELAY.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- keypad_col_in  input  4  column drive from the scanner; one-hot while a key is held.
- row_in  input  4  latched row from the scanner; one-hot for a valid single key.
- key_pressed  input  1  scanner level; high while a debounced key is held.
- key_code  output  4  FIFO head code.
- key_valid  output  1  FIFO non-empty.
- key_ready  input  1  consumer accept; a pop occurs when key_valid && key_ready.
- key_error  output  1  one-cycle pulse on a press with non-one-hot row or column.
- overflow  output  1  sticky; set on a push dropped because the FIFO is full.
- clear  input  1  synchronous; empties the FIFO, clears overflow, returns FSM to IDLE.

Behaviour:
- Clock and reset: one clock domain (clk); reset is asynchronous and active-high (rst).
- Reset values: key_code=0, key_valid=0, key_error=0, overflow=0; FIFO empty; FSM IDLE; counters 0; key_pressed_d=0.
- Press event: rising edge of key_pressed, i.e. key_pressed=1 and registered key_pressed_d=0.
- Sampling: row_in and keypad_col_in are sampled in the same cycle as the press event.
- Decode: r = bit index of row_in, c = bit index of keypad_col_in.
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E('*'), 0, F('#'), D
- Invalid press: row or column not exactly one-hot (zero or multiple bits). key_error pulses for 1 cycle, nothing is pushed, FSM goes to WAIT_RELEASE.
- Valid press: the code is pushed on that clock edge and held in a code register. If the FIFO was empty, key_valid=1 and key_code=the new code in the next cycle (latency 1).
- FSM states:
  - IDLE: on valid press -> HELD (cnt=0); on invalid press -> WAIT_RELEASE.
  - HELD: key_pressed=0 -> IDLE. Else cnt++; when REPEAT_DELAY!=0 and cnt==REPEAT_DELAY-1, push the held code, cnt=0, go to REPEAT. REPEAT_DELAY==0 -> stays in HELD, no repeats.
  - REPEAT: key_pressed=0 -> IDLE. Else cnt++; when REPEAT_RATE!=0 and cnt==REPEAT_RATE-1, push the held code, cnt=0. REPEAT_RATE==0 -> no further pushes.
  - WAIT_RELEASE: key_pressed=0 -> IDLE.
- Repeat pushes use the stored code; row/col inputs are not re-sampled while held.
- FIFO: circular buffer with log2(DEPTH)+1-bit read/write pointers; pointers wrap modulo DEPTH.
  - Full when pointer MSBs differ and the lower bits are equal; empty when the pointers are equal.
  - key_code is driven combinationally from mem[rd_ptr].
- Push while full with no pop: the push is dropped, overflow is set, stored data is unchanged.
- Push and pop in the same cycle while full: both succeed; count unchanged; no overflow.
- Push and pop in the same cycle while empty: the push succeeds; the pop is ignored (key_valid was 0).
- Pop while empty: ignored.
- clear: highest synchronous priority. A concurrent push is discarded and key_error is suppressed.
- Reset mid-hold: FSM returns to IDLE with key_pressed_d=0. If key_pressed is still high after reset release, it counts as a new press event.
- key_pressed falling and a repeat tick in the same cycle: the release wins, no push.

Test Plan:
- Press (row_in=0100, col=0010, key_pressed 0->1, held 10 cycles), key_ready=1 -> key_valid high 1 cycle after the edge with key_code=8; exactly one pop; key_valid=0 afterwards.
- Invalid press (row_in=0110, col=0001) -> key_error pulses 1 cycle; no push; a following valid press (row 1000, col 0100, code F) is accepted only after key_pressed falls and rises again.
- key_ready=0, five distinct valid presses with DEPTH=4 -> FIFO holds the first four codes in order; overflow=1 and stays set. Then key_ready=1 -> the four codes drain in order. Then clear -> overflow=0.
- REPEAT_DELAY=8, REPEAT_RATE=4, key '5' held 30 cycles -> pushes at the edge, +8, +12, +16, +20, +24, +28 (7 codes, all 5); release stops further pushes.
- FIFO full, key_ready=1, and a new press in the same cycle -> head popped, new code written, count stays 4, overflow stays 0.
- Assert rst mid-REPEAT with the FIFO holding 2 codes -> all outputs immediately 0 and FIFO empty. key_pressed still high at rst release -> one new push of the sampled code.
